// File: rtl/note_frame_scheduler.sv
// note_frame_scheduler: owns the 8x8 red/green frame buffers, scrolls spawned notes toward
// the hit row on a divided tick, resolves player hits and runs a row-by-row clear sequence.
module note_frame_scheduler #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic              i_spawn_valid,
    input  logic [7:0]        i_spawn_mask,
    output logic              o_spawn_ready,
    input  logic              i_hit_valid,
    input  logic [2:0]        i_hit_col,
    output logic [7:0][7:0]   o_red_array,
    output logic [7:0][7:0]   o_green_array,
    output logic              o_scroll_tick,
    output logic              o_hit_pulse,
    output logic              o_bad_hit_pulse,
    output logic              o_miss_pulse,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic [CNT_W-1:0]  o_miss_count,
    output logic              o_busy
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {STOPPED, RUNNING, CLEARING} state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_clr_row;
    logic [7:0]         r_pend;
    logic               r_pend_v;
    logic [7:0][7:0]    r_red;
    logic [7:0]         r_green7;
    logic               r_tick, r_hit, r_bad, r_miss;
    logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt;

    logic               w_ready, w_accept, w_step, w_good;
    logic [7:0]         w_col_bit, w_row7, w_row0;
    logic [3:0]         w_miss_n;
    logic [CNT_W+3:0]   w_miss_sum;
    logic [CNT_W-1:0]   w_miss_next, w_hit_next;

    assign w_ready     = (r_state == RUNNING) && !r_pend_v;
    assign w_accept    = i_spawn_valid && w_ready;
    assign w_step      = r_div == DIV_W'(TICK_DIV - 1);
    assign w_col_bit   = 8'b1 << i_hit_col;
    assign w_good      = i_hit_valid && r_red[7][i_hit_col];
    // A note that is hit this cycle leaves row 7 before the miss count looks at it.
    assign w_row7      = r_red[7] & ~(w_good ? w_col_bit : 8'h00);
    assign w_row0      = r_pend_v ? r_pend : (w_accept ? i_spawn_mask : 8'h00);
    assign w_miss_n    = 4'($countones(w_row7));
    assign w_miss_sum  = (CNT_W+4)'(r_miss_cnt) + (CNT_W+4)'(w_miss_n);
    assign w_miss_next = (w_miss_sum > (CNT_W+4)'(CNT_MAX)) ? CNT_MAX : w_miss_sum[CNT_W-1:0];
    assign w_hit_next  = (&r_hit_cnt) ? r_hit_cnt : r_hit_cnt + 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= STOPPED;
            r_div      <= '0;
            r_clr_row  <= '0;
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_red      <= '0;
            r_green7   <= '0;
            r_tick     <= 1'b0;
            r_hit      <= 1'b0;
            r_bad      <= 1'b0;
            r_miss     <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_tick <= 1'b0;
            r_hit  <= 1'b0;
            r_bad  <= 1'b0;
            r_miss <= 1'b0;
            case (r_state)
                CLEARING: begin
                    r_red[r_clr_row] <= 8'h00;
                    r_clr_row        <= r_clr_row + 3'd1;
                    if (r_clr_row == 3'd7) begin
                        r_green7   <= '0;
                        r_hit_cnt  <= '0;
                        r_miss_cnt <= '0;
                        r_pend_v   <= 1'b0;
                        r_state    <= i_run ? RUNNING : STOPPED;
                    end
                end
                STOPPED: begin
                    if (i_clear) begin
                        r_state   <= CLEARING;
                        r_clr_row <= '0;
                    end else if (i_run) begin
                        r_state <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (i_clear) begin
                        r_state   <= CLEARING;
                        r_clr_row <= '0;
                    end else begin
                        r_div <= w_step ? '0 : r_div + 1'b1;
                        if (!i_run) r_state <= STOPPED;
                        r_hit <= w_good;
                        r_bad <= i_hit_valid && !w_good;
                        if (w_good) r_hit_cnt <= w_hit_next;
                        // Hits are judged on the pre-shift row; the flash lands on the new row 7.
                        if (w_step) begin
                            r_red      <= {r_red[6:0], w_row0};
                            r_pend_v   <= 1'b0;
                            r_tick     <= 1'b1;
                            r_miss     <= |w_row7;
                            r_miss_cnt <= w_miss_next;
                            r_green7   <= w_good ? w_col_bit : 8'h00;
                        end else begin
                            r_red[7]  <= w_row7;
                            r_green7  <= r_green7 | (w_good ? w_col_bit : 8'h00);
                            if (w_accept) begin
                                r_pend   <= i_spawn_mask;
                                r_pend_v <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= STOPPED;
            endcase
        end
    end

    assign o_spawn_ready   = w_ready;
    assign o_red_array     = r_red;
    assign o_green_array   = {r_green7, 56'h0};
    assign o_scroll_tick   = r_tick;
    assign o_hit_pulse     = r_hit;
    assign o_bad_hit_pulse = r_bad;
    assign o_miss_pulse    = r_miss;
    assign o_hit_count     = r_hit_cnt;
    assign o_miss_count    = r_miss_cnt;
    assign o_busy          = r_state == CLEARING;
endmodule

// File: tb/tb_note_frame_scheduler.sv
// tb_note_frame_scheduler: directed vector table, random stimulus against a frame-level
// reference model, and hand-written clear / async-reset sequences.
module tb_note_frame_scheduler;
    localparam int TD  = 4;
    localparam int CW  = 4;
    localparam int MAX = 15;

    logic clk = 1'b0, rst = 1'b0;
    logic run = 0, clr = 0, sv = 0, hv = 0;
    logic [7:0] mask = 0;
    logic [2:0] col = 0;
    logic ready, tick, hp, bp, mp, busy;
    logic [7:0][7:0] red, green;
    logic [CW-1:0] hc, mc;

    note_frame_scheduler #(.TICK_DIV(TD), .CNT_W(CW)) dut (
        .i_clock(clk), .i_reset(rst), .i_run(run), .i_clear(clr),
        .i_spawn_valid(sv), .i_spawn_mask(mask), .o_spawn_ready(ready),
        .i_hit_valid(hv), .i_hit_col(col),
        .o_red_array(red), .o_green_array(green),
        .o_scroll_tick(tick), .o_hit_pulse(hp), .o_bad_hit_pulse(bp), .o_miss_pulse(mp),
        .o_hit_count(hc), .o_miss_count(mc), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Reference model: mode 0 stopped, 1 running, 2 clearing.
    int ms, mdiv, mclr, mhit, mmiss;
    bit mpv, mtick, mhp, mbp, mmp;
    logic [7:0] mpend, mg7;
    logic [7:0] mred [8];

    task automatic model_reset();
        ms = 0; mdiv = 0; mclr = 0; mhit = 0; mmiss = 0;
        mpv = 0; mtick = 0; mhp = 0; mbp = 0; mmp = 0; mpend = 0; mg7 = 0;
        for (int r = 0; r < 8; r++) mred[r] = 0;
    endtask

    task automatic model_step();
        bit acc, step, good;
        logic [7:0] row7;
        acc = sv && ms == 1 && !mpv;
        mtick = 0; mhp = 0; mbp = 0; mmp = 0;
        if (ms == 2) begin
            mred[mclr] = 0;
            if (mclr == 7) begin
                mg7 = 0; mhit = 0; mmiss = 0; mpv = 0;
                ms = run ? 1 : 0;
            end else mclr++;
        end else if (clr) begin
            ms = 2; mclr = 0;
        end else if (ms == 0) begin
            if (run) ms = 1;
        end else begin
            step = mdiv == TD - 1;
            mdiv = step ? 0 : mdiv + 1;
            row7 = mred[7];
            good = hv && row7[col];
            if (hv && good) begin
                mhp = 1; mhit = (mhit + 1 > MAX) ? MAX : mhit + 1; row7[col] = 0;
            end else if (hv) mbp = 1;
            if (step) begin
                for (int r = 7; r > 0; r--) mred[r] = mred[r-1];
                mred[0] = mpv ? mpend : (acc ? mask : 8'h00);
                mpv = 0;
                mmp = row7 != 0;
                mmiss = (mmiss + $countones(row7) > MAX) ? MAX : mmiss + $countones(row7);
                mg7 = good ? (8'h01 << col) : 8'h00;
                mtick = 1;
            end else begin
                mred[7] = row7;
                if (good) mg7[col] = 1'b1;
                if (acc) begin mpend = mask; mpv = 1; end
            end
            if (!run) ms = 0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [7:0][7:0] er;
        for (int r = 0; r < 8; r++) er[r] = mred[r];
        chk("red", red, er);
        chk("green", green, {mg7, 56'h0});
        chk("pulses", {60'h0, tick, hp, bp, mp}, {60'h0, mtick, mhp, mbp, mmp});
        chk("counts", {56'h0, hc, mc}, {56'h0, 4'(mhit), 4'(mmiss)});
        chk("ready_busy", {62'h0, ready, busy}, {62'h0, ms == 1 && !mpv, ms == 2});
    endtask

    task automatic cycle(input bit i_run, input bit i_clr, input bit i_sv, input logic [7:0] i_mask,
                         input bit i_hv, input logic [2:0] i_col);
        run = i_run; clr = i_clr; sv = i_sv; mask = i_mask; hv = i_hv; col = i_col;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("reset_all", {red[7:4], 32'h0} | {32'h0, green[7:4]}, 64'h0);
        chk("reset_ctl", {52'h0, tick, hp, bp, mp, hc, mc} | {62'h0, ready, busy}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit run, clr, sv; logic [7:0] mask; bit hv; logic [2:0] col; int n;
        bit ready, busy; logic [3:0] pl; int hc, mc; logic [7:0] r0, r7, g7;
    } vec_t;
    vec_t tbl[$];

    initial begin
        // pl = {scroll_tick, hit_pulse, bad_hit_pulse, miss_pulse}
        tbl.push_back('{1,0,1,8'h81,0,3'd0, 1, 1,0,4'b0000,0,0,8'h00,8'h00,8'h00});
        tbl.push_back('{1,0,1,8'h81,0,3'd0, 1, 0,0,4'b0000,0,0,8'h00,8'h00,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 3, 1,0,4'b1000,0,0,8'h81,8'h00,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0,28, 1,0,4'b1000,0,0,8'h00,8'h81,8'h00});
        tbl.push_back('{1,0,0,8'h00,1,3'd0, 1, 1,0,4'b0100,1,0,8'h00,8'h80,8'h01});
        tbl.push_back('{1,0,0,8'h00,1,3'd5, 1, 1,0,4'b0010,1,0,8'h00,8'h80,8'h01});
        tbl.push_back('{1,0,0,8'h00,1,3'd7, 1, 1,0,4'b0100,2,0,8'h00,8'h00,8'h81});
        tbl.push_back('{1,0,1,8'h08,0,3'd0, 1, 1,0,4'b1000,2,0,8'h08,8'h00,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0,28, 1,0,4'b1000,2,0,8'h00,8'h08,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 3, 1,0,4'b0000,2,0,8'h00,8'h08,8'h00});
        tbl.push_back('{1,0,0,8'h00,1,3'd3, 1, 1,0,4'b1100,3,0,8'h00,8'h00,8'h08});
        tbl.push_back('{1,0,1,8'h3C,0,3'd0, 1, 0,0,4'b0000,3,0,8'h00,8'h00,8'h08});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 3, 1,0,4'b1000,3,0,8'h3C,8'h00,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0,28, 1,0,4'b1000,3,0,8'h00,8'h3C,8'h00});
        tbl.push_back('{0,0,0,8'h00,0,3'd0, 1, 0,0,4'b0000,3,0,8'h00,8'h3C,8'h00});
        tbl.push_back('{0,0,1,8'hFF,0,3'd0,10, 0,0,4'b0000,3,0,8'h00,8'h3C,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 1, 1,0,4'b0000,3,0,8'h00,8'h3C,8'h00});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 2, 1,0,4'b0000,3,0,8'h00,8'h3C,8'h00});
        tbl.push_back('{1,0,0,8'h00,1,3'd2, 1, 1,0,4'b1101,4,3,8'h00,8'h00,8'h04});
        tbl.push_back('{1,1,0,8'h00,0,3'd0, 1, 0,1,4'b0000,4,3,8'h00,8'h00,8'h04});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 7, 0,1,4'b0000,4,3,8'h00,8'h00,8'h04});
        tbl.push_back('{1,0,0,8'h00,0,3'd0, 1, 1,0,4'b0000,0,0,8'h00,8'h00,8'h00});

        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("reset_red_green", red | green, 64'h0);
        chk("reset_ctl", {52'h0, tick, hp, bp, mp, hc, mc} | {62'h0, ready, busy}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                cycle(tbl[i].run, tbl[i].clr, tbl[i].sv, tbl[i].mask, tbl[i].hv, tbl[i].col);
            chk($sformatf("vec%0d_ready_busy", i), {62'h0, ready, busy}, {62'h0, tbl[i].ready, tbl[i].busy});
            chk($sformatf("vec%0d_pulses", i), {60'h0, tick, hp, bp, mp}, {60'h0, tbl[i].pl});
            chk($sformatf("vec%0d_counts", i), {56'h0, hc, mc}, {56'h0, 4'(tbl[i].hc), 4'(tbl[i].mc)});
            chk($sformatf("vec%0d_rows", i), {40'h0, red[0], red[7], green[7]},
                {40'h0, tbl[i].r0, tbl[i].r7, tbl[i].g7});
        end

        // Fill the whole frame, then clear and watch rows vanish top first.
        for (int k = 0; k < 40; k++) cycle(1, 0, 1, 8'hFF, 0, 3'd0);
        chk("full_frame", red, {8{8'hFF}});
        cycle(1, 1, 0, 8'h00, 0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("clr%0d_busy", k), {63'h0, busy}, 64'h1);
            cycle(1, 0, 0, 8'h00, 1, 3'd0);
            chk($sformatf("clr%0d_row_zero", k), {56'h0, red[k]}, 64'h0);
            if (k < 7) chk($sformatf("clr%0d_next_row_kept", k), {56'h0, red[k+1]}, 64'hFF);
        end
        chk("clr_done", {55'h0, busy, hc, mc}, 64'h0);

        // Random traffic with occasional pauses and clears.
        for (int k = 0; k < 4000; k++) begin
            logic [2:0] c;
            logic [7:0] m;
            c = 3'($urandom_range(0, 7));
            if (mred[7] != 0 && $urandom_range(0, 1) == 1)
                for (int b = 7; b >= 0; b--) if (mred[7][b]) c = 3'(b);
            m = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                  m, $urandom_range(0, 2) == 0, c);
        end

        // Async reset in the middle of a clear.
        for (int k = 0; k < 40; k++) cycle(1, 0, 1, 8'hFF, k % 2 == 1, 3'd0);
        cycle(1, 1, 0, 8'h00, 0, 3'd0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 8'h00, 0, 3'd0);
        chk("mid_clear_busy", {63'h0, busy}, 64'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_reset_arrays", red | green, 64'h0);
        chk("async_reset_ctl", {52'h0, tick, hp, bp, mp, hc, mc} | {62'h0, ready, busy}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 200; k++)
            cycle(1, 0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
